// File: rtl/dec_stage_if.sv
// Decode-stage bus: IF/ID inputs, register-file read port and ID/EX outputs.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface dec_stage_if;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic [31:0] i_nxt_pc;
  logic        i_vld;
  logic        i_flush;
  logic        i_stall;
  logic [4:0]  o_rs1_raddr;
  logic [4:0]  o_rs2_raddr;
  logic [31:0] i_rs1_rdata;
  logic [31:0] i_rs2_rdata;
  logic        o_hold;
  logic        o_halt;
  logic        o_ex_vld;
  logic [31:0] o_ex_pc;
  logic [31:0] o_ex_nxt_pc;
  logic [31:0] o_ex_rs1;
  logic [31:0] o_ex_rs2;
  logic [31:0] o_ex_imm;
  logic [4:0]  o_ex_rd;
  logic [2:0]  o_ex_opsel;
  logic [9:0]  o_ex_ctrl;
  logic        o_ex_halt;

  modport slave (
    input  i_inst, i_pc, i_nxt_pc, i_vld, i_flush, i_stall, i_rs1_rdata, i_rs2_rdata,
    output o_rs1_raddr, o_rs2_raddr, o_hold, o_halt, o_ex_vld, o_ex_pc, o_ex_nxt_pc,
           o_ex_rs1, o_ex_rs2, o_ex_imm, o_ex_rd, o_ex_opsel, o_ex_ctrl, o_ex_halt
  );

  modport master (
    output i_inst, i_pc, i_nxt_pc, i_vld, i_flush, i_stall, i_rs1_rdata, i_rs2_rdata,
    input  o_rs1_raddr, o_rs2_raddr, o_hold, o_halt, o_ex_vld, o_ex_pc, o_ex_nxt_pc,
           o_ex_rs1, o_ex_rs2, o_ex_imm, o_ex_rd, o_ex_opsel, o_ex_ctrl, o_ex_halt
  );
endinterface

// File: rtl/dec_stage.sv
// RV32I decode stage: decodes the IF/ID instruction into the ID/EX register,
// detects load-use hazards (holding fetch) and latches a sticky halt.
module dec_stage #(
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input logic        i_clk,
  input logic        i_rst,
  dec_stage_if.slave bus
);

  typedef struct packed {
    logic sub_sra;
    logic alu_imm;
    logic mem_rd;
    logic mem_wr;
    logic reg_wr;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } ctrl_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] nxt_pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  opsel;
    ctrl_t       ctrl;
    logic        halt;
  } ex_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  ex_t  ex_q, ex_d, dec_s;
  logic halt_q, halt_d;
  logic uses_rs1_s, uses_rs2_s, hazard_s;
  logic [31:0] inst_s;

  assign inst_s = bus.i_inst;

  // Decode the IF/ID instruction into a candidate ID/EX entry.
  always_comb begin
    dec_s        = '0;
    uses_rs1_s   = 1'b1;
    uses_rs2_s   = 1'b0;
    dec_s.vld    = 1'b1;
    dec_s.pc     = bus.i_pc;
    dec_s.nxt_pc = bus.i_nxt_pc;
    dec_s.rs1    = bus.i_rs1_rdata;
    dec_s.rs2    = bus.i_rs2_rdata;
    dec_s.opsel  = inst_s[14:12];
    case (inst_s[6:0])
      OPC_LUI: begin
        dec_s.ctrl.lui    = 1'b1;
        dec_s.ctrl.reg_wr = 1'b1;
        dec_s.imm         = imm_u(inst_s);
        uses_rs1_s        = 1'b0;
      end
      OPC_AUIPC: begin
        dec_s.ctrl.auipc  = 1'b1;
        dec_s.ctrl.reg_wr = 1'b1;
        dec_s.imm         = imm_u(inst_s);
        uses_rs1_s        = 1'b0;
      end
      OPC_JAL: begin
        dec_s.ctrl.jal    = 1'b1;
        dec_s.ctrl.reg_wr = 1'b1;
        dec_s.imm         = imm_j(inst_s);
        uses_rs1_s        = 1'b0;
      end
      OPC_JALR: begin
        dec_s.ctrl.jalr    = 1'b1;
        dec_s.ctrl.reg_wr  = 1'b1;
        dec_s.ctrl.alu_imm = 1'b1;
        dec_s.imm          = imm_i(inst_s);
      end
      OPC_BRANCH: begin
        dec_s.ctrl.branch = 1'b1;
        dec_s.imm         = imm_b(inst_s);
        uses_rs2_s        = 1'b1;
      end
      OPC_LOAD: begin
        dec_s.ctrl.mem_rd  = 1'b1;
        dec_s.ctrl.reg_wr  = 1'b1;
        dec_s.ctrl.alu_imm = 1'b1;
        dec_s.imm          = imm_i(inst_s);
      end
      OPC_STORE: begin
        dec_s.ctrl.mem_wr  = 1'b1;
        dec_s.ctrl.alu_imm = 1'b1;
        dec_s.imm          = imm_s(inst_s);
        uses_rs2_s         = 1'b1;
      end
      OPC_OPIMM: begin
        dec_s.ctrl.reg_wr  = 1'b1;
        dec_s.ctrl.alu_imm = 1'b1;
        dec_s.ctrl.sub_sra = (inst_s[14:12] == 3'b101) & inst_s[30];
        dec_s.imm          = imm_i(inst_s);
      end
      OPC_OP: begin
        dec_s.ctrl.reg_wr  = 1'b1;
        dec_s.ctrl.sub_sra = ((inst_s[14:12] == 3'b000) | (inst_s[14:12] == 3'b101)) & inst_s[30];
        uses_rs2_s         = 1'b1;
      end
      // FENCE has no effect on this in-order pipeline; it passes as a no-op.
      OPC_FENCE: begin
        dec_s.imm = imm_i(inst_s);
      end
      OPC_SYSTEM: begin
        dec_s.halt = 1'b1;
        dec_s.imm  = imm_i(inst_s);
      end
      default: begin
        dec_s.halt = 1'b1;
      end
    endcase
    dec_s.rd = dec_s.ctrl.reg_wr ? inst_s[11:7] : 5'd0;
  end

  assign hazard_s = LOAD_USE_STALL & bus.i_vld & ex_q.vld & ex_q.ctrl.mem_rd & (ex_q.rd != 5'd0)
                  & (((ex_q.rd == inst_s[19:15]) & uses_rs1_s) | ((ex_q.rd == inst_s[24:20]) & uses_rs2_s));

  // ID/EX next state: flush > hazard > stall > halted > load.
  always_comb begin
    ex_d   = ex_q;
    halt_d = halt_q;
    if (bus.i_flush || hazard_s) begin
      ex_d = '0;
    end else if (bus.i_stall) begin
      ex_d = ex_q;
    end else if (halt_q || !bus.i_vld) begin
      ex_d = '0;
    end else begin
      ex_d   = dec_s;
      halt_d = halt_q | dec_s.halt;
    end
  end

  // ID/EX pipeline register and sticky halt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_q   <= '0;
      halt_q <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      halt_q <= halt_d;
    end
  end

  assign bus.o_rs1_raddr = inst_s[19:15];
  assign bus.o_rs2_raddr = inst_s[24:20];
  assign bus.o_hold      = !i_rst & !bus.i_flush & (hazard_s | bus.i_stall);
  assign bus.o_halt      = halt_q;
  assign bus.o_ex_vld    = ex_q.vld;
  assign bus.o_ex_pc     = ex_q.pc;
  assign bus.o_ex_nxt_pc = ex_q.nxt_pc;
  assign bus.o_ex_rs1    = ex_q.rs1;
  assign bus.o_ex_rs2    = ex_q.rs2;
  assign bus.o_ex_imm    = ex_q.imm;
  assign bus.o_ex_rd     = ex_q.rd;
  assign bus.o_ex_opsel  = ex_q.opsel;
  assign bus.o_ex_ctrl   = ex_q.ctrl;
  assign bus.o_ex_halt   = ex_q.halt;

endmodule

// File: tb/tb_dec_stage.sv
// Bench for dec_stage: directed scenarios plus random traffic, both DUT variants
// (with and without load-use detection) checked every cycle against a behavioural model.
module tb_dec_stage;

  localparam int SUB = 9, IMM = 8, MRD = 7, MWR = 6, RWR = 5, BR = 4, JL = 3, JLR = 2, LU = 1, AUI = 0;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [9:0]  ctrl;
    logic        xhalt;
    logic        halt;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic started = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] rf [32];
  mdl_t m0, m1, d0, d1;

  logic [6:0] known_ops [9]   = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  logic [6:0] unknown_ops [5] = '{7'h7F, 7'h0B, 7'h2B, 7'h5B, 7'h00};

  always #5 clk = ~clk;

  dec_stage_if bus0();
  dec_stage_if bus1();

  dec_stage #(.LOAD_USE_STALL(1'b1)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  dec_stage #(.LOAD_USE_STALL(1'b0)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

  assign bus1.i_inst   = bus0.i_inst;
  assign bus1.i_pc     = bus0.i_pc;
  assign bus1.i_nxt_pc = bus0.i_nxt_pc;
  assign bus1.i_vld    = bus0.i_vld;
  assign bus1.i_flush  = bus0.i_flush;
  assign bus1.i_stall  = bus0.i_stall;
  assign bus0.i_rs1_rdata = rf[bus0.o_rs1_raddr];
  assign bus0.i_rs2_rdata = rf[bus0.o_rs2_raddr];
  assign bus1.i_rs1_rdata = rf[bus1.o_rs1_raddr];
  assign bus1.i_rs2_rdata = rf[bus1.o_rs2_raddr];

  assign d0 = {bus0.o_ex_vld, bus0.o_ex_pc, bus0.o_ex_nxt_pc, bus0.o_ex_rs1, bus0.o_ex_rs2, bus0.o_ex_imm,
               bus0.o_ex_rd, bus0.o_ex_opsel, bus0.o_ex_ctrl, bus0.o_ex_halt, bus0.o_halt};
  assign d1 = {bus1.o_ex_vld, bus1.o_ex_pc, bus1.o_ex_nxt_pc, bus1.o_ex_rs1, bus1.o_ex_rs2, bus1.o_ex_imm,
               bus1.o_ex_rd, bus1.o_ex_opsel, bus1.o_ex_ctrl, bus1.o_ex_halt, bus1.o_halt};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: what an instruction means, written from the ISA tables.
  function automatic mdl_t m_decode(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] npc);
    mdl_t d = '0;
    logic signed [31:0] s = $signed(w);
    logic [31:0] i_imm = 32'(s >>> 20);
    logic [31:0] s_imm = 32'((s >>> 25) <<< 5) | 32'(w[11:7]);
    logic [31:0] b_imm = (w[31] ? 32'hFFFFF000 : 32'h0) + (32'(w[7]) << 11) + (32'(w[30:25]) << 5) + (32'(w[11:8]) << 1);
    logic [31:0] u_imm = w & 32'hFFFFF000;
    logic [31:0] j_imm = (w[31] ? 32'hFFF00000 : 32'h0) + (32'(w[19:12]) << 12) + (32'(w[20]) << 11) + (32'(w[30:21]) << 1);
    d.vld = 1'b1; d.pc = pc; d.npc = npc; d.f3 = w[14:12];
    d.rs1 = rf[w[19:15]]; d.rs2 = rf[w[24:20]];
    case (w[6:0])
      7'h37: begin d.ctrl[RWR] = 1'b1; d.ctrl[LU]  = 1'b1; d.imm = u_imm; end
      7'h17: begin d.ctrl[RWR] = 1'b1; d.ctrl[AUI] = 1'b1; d.imm = u_imm; end
      7'h6F: begin d.ctrl[RWR] = 1'b1; d.ctrl[JL]  = 1'b1; d.imm = j_imm; end
      7'h67: begin d.ctrl[RWR] = 1'b1; d.ctrl[JLR] = 1'b1; d.ctrl[IMM] = 1'b1; d.imm = i_imm; end
      7'h63: begin d.ctrl[BR]  = 1'b1; d.imm = b_imm; end
      7'h03: begin d.ctrl[RWR] = 1'b1; d.ctrl[MRD] = 1'b1; d.ctrl[IMM] = 1'b1; d.imm = i_imm; end
      7'h23: begin d.ctrl[MWR] = 1'b1; d.ctrl[IMM] = 1'b1; d.imm = s_imm; end
      7'h13: begin d.ctrl[RWR] = 1'b1; d.ctrl[IMM] = 1'b1; d.imm = i_imm; d.ctrl[SUB] = (w[14:12] == 3'd5) && w[30]; end
      7'h33: begin d.ctrl[RWR] = 1'b1; d.ctrl[SUB] = (w[14:12] == 3'd0 || w[14:12] == 3'd5) && w[30]; end
      7'h0F: begin d.imm = i_imm; end
      7'h73: begin d.xhalt = 1'b1; d.imm = i_imm; end
      default: d.xhalt = 1'b1;
    endcase
    d.rd = d.ctrl[RWR] ? w[11:7] : 5'd0;
    return d;
  endfunction

  function automatic bit m_hazard(input mdl_t cur, input bit lus);
    logic [31:0] w = bus0.i_inst;
    bit u1 = !(w[6:0] inside {7'h37, 7'h17, 7'h6F});
    bit u2 = w[6:0] inside {7'h33, 7'h23, 7'h63};
    return lus && (bus0.i_vld === 1'b1) && cur.vld && cur.ctrl[MRD] && (cur.rd != 5'd0)
        && (((cur.rd == w[19:15]) && u1) || ((cur.rd == w[24:20]) && u2));
  endfunction

  function automatic mdl_t m_next(input mdl_t cur, input bit lus);
    mdl_t bub = '0;
    mdl_t n   = cur;
    bub.halt = cur.halt;
    if (rst) n = '0;
    else if (bus0.i_flush || m_hazard(cur, lus)) n = bub;
    else if (bus0.i_stall) n = cur;
    else if (cur.halt || !bus0.i_vld) n = bub;
    else begin
      n = m_decode(bus0.i_inst, bus0.i_pc, bus0.i_nxt_pc);
      n.halt = n.xhalt;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 <= m_next(m0, 1'b1);
    m1 <= m_next(m1, 1'b0);
  end

  task automatic cmp(input string tag, input mdl_t d, input mdl_t m, input bit lus,
                     input logic hold, input logic [4:0] ra1, input logic [4:0] ra2);
    check({tag, "_vld"},   32'(d.vld),   32'(m.vld));
    check({tag, "_pc"},    d.pc,         m.pc);
    check({tag, "_npc"},   d.npc,        m.npc);
    check({tag, "_rs1"},   d.rs1,        m.rs1);
    check({tag, "_rs2"},   d.rs2,        m.rs2);
    check({tag, "_imm"},   d.imm,        m.imm);
    check({tag, "_rd"},    32'(d.rd),    32'(m.rd));
    check({tag, "_opsel"}, 32'(d.f3),    32'(m.f3));
    check({tag, "_ctrl"},  32'(d.ctrl),  32'(m.ctrl));
    check({tag, "_exhlt"}, 32'(d.xhalt), 32'(m.xhalt));
    check({tag, "_halt"},  32'(d.halt),  32'(m.halt));
    check({tag, "_hold"},  32'(hold),    32'(!rst && !bus0.i_flush && (m_hazard(m, lus) || bus0.i_stall)));
    check({tag, "_ra1"},   32'(ra1),     32'(bus0.i_inst[19:15]));
    check({tag, "_ra2"},   32'(ra2),     32'(bus0.i_inst[24:20]));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("lus1", d0, m0, 1'b1, bus0.o_hold, bus0.o_rs1_raddr, bus0.o_rs2_raddr);
      cmp("lus0", d1, m1, 1'b0, bus1.o_hold, bus1.o_rs1_raddr, bus1.o_rs2_raddr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] w, input logic [31:0] pc);
    bus0.i_inst   = w;
    bus0.i_pc     = pc;
    bus0.i_nxt_pc = pc + 32'd4;
    bus0.i_vld    = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    w[19:15] = 5'($urandom_range(7));
    w[24:20] = 5'($urandom_range(7));
    w[11:7]  = 5'($urandom_range(7));
    if ($urandom_range(99) < 3) w[6:0] = ($urandom_range(1) == 0) ? 7'h73 : unknown_ops[$urandom_range(4)];
    else if ($urandom_range(99) < 25) w[6:0] = 7'h03;
    else w[6:0] = known_ops[$urandom_range(8)];
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
    bus0.i_inst = 32'h0; bus0.i_pc = 32'h0; bus0.i_nxt_pc = 32'h0;
    bus0.i_vld = 1'b0; bus0.i_flush = 1'b0; bus0.i_stall = 1'b1;
    rst = 1'b1;
    step();
    started = 1'b1;
    step();
    check("rst_ex_vld", 32'(bus0.o_ex_vld), 32'd0);
    check("rst_halt",   32'(bus0.o_halt),   32'd0);
    check("rst_hold",   32'(bus0.o_hold),   32'd0);
    bus0.i_stall = 1'b0;
    rst = 1'b0;

    drv(32'h00500093, 32'h100);
    step();
    check("addi_vld",  32'(bus0.o_ex_vld), 32'd1);
    check("addi_imm",  bus0.o_ex_imm,      32'd5);
    check("addi_rd",   32'(bus0.o_ex_rd),  32'd1);
    check("addi_ctrl", 32'(bus0.o_ex_ctrl), 32'h120);
    check("addi_pc",   bus0.o_ex_pc,       32'h100);
    check("addi_mdl_imm", m0.imm,          32'd5);

    drv(32'h00012283, 32'h104);
    step();
    drv(32'h00728333, 32'h108);
    #1;
    check("lu_hold",        32'(bus0.o_hold), 32'd1);
    check("lu_hold_nodet",  32'(bus1.o_hold), 32'd0);
    step();
    check("lu_bubble",      32'(bus0.o_ex_vld), 32'd0);
    check("lu_hold_1cyc",   32'(bus0.o_hold),   32'd0);
    step();
    check("lu_add_vld",     32'(bus0.o_ex_vld), 32'd1);
    check("lu_add_rd",      32'(bus0.o_ex_rd),  32'd6);

    drv(32'h00012003, 32'h10C);
    step();
    drv(32'h00700333, 32'h110);
    #1;
    check("x0_hold", 32'(bus0.o_hold), 32'd0);
    step();
    check("x0_nobubble", 32'(bus0.o_ex_vld), 32'd1);
    check("x0_rd",       32'(bus0.o_ex_rd),  32'd6);

    drv(32'h00012283, 32'h114);
    step();
    drv(32'h00728333, 32'h118);
    bus0.i_flush = 1'b1;
    bus0.i_stall = 1'b1;
    #1;
    check("fl_hold", 32'(bus0.o_hold), 32'd0);
    step();
    check("fl_bubble", 32'(bus0.o_ex_vld), 32'd0);
    bus0.i_flush = 1'b0;
    bus0.i_stall = 1'b0;

    drv(32'h00500093, 32'h200);
    step();
    bus0.i_stall = 1'b1;
    drv(32'hFE000CE3, 32'h204);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_hold", 32'(bus0.o_hold), 32'd1);
      step();
      check("st_frozen_pc", bus0.o_ex_pc, 32'h200);
    end
    bus0.i_stall = 1'b0;
    #1;
    check("st_release", 32'(bus0.o_hold), 32'd0);

    drv(32'hFE000CE3, 32'h300);
    step();
    check("beq_imm",  bus0.o_ex_imm,        32'hFFFFFFF8);
    check("beq_ctrl", 32'(bus0.o_ex_ctrl),  32'h010);
    check("beq_rd",   32'(bus0.o_ex_rd),    32'd0);
    check("beq_mdl_imm", m0.imm,            32'hFFFFFFF8);

    drv(32'h00100073, 32'h304);
    step();
    check("ebk_exhalt", 32'(bus0.o_ex_halt), 32'd1);
    check("ebk_halt",   32'(bus0.o_halt),    32'd1);
    drv(32'h00500093, 32'h308);
    step();
    check("hlt_bubble", 32'(bus0.o_ex_vld), 32'd0);
    step();
    check("hlt_sticky", 32'(bus0.o_halt), 32'd1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(99) < 2);
      bus0.i_flush = ($urandom_range(99) < 6);
      bus0.i_stall = ($urandom_range(99) < 12);
      bus0.i_vld   = ($urandom_range(99) < 85);
      bus0.i_inst  = rand_inst();
      bus0.i_pc    = $urandom;
      bus0.i_nxt_pc = bus0.i_pc + 32'd4;
      step();
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
